// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_pkg
// Purpose  : Shared definitions for the instruction fetch slice: default
//            widths shared with the decoder, the default sequential PC
//            increment, the fetch FSM state encoding and a saturating
//            counter helper used by the optional performance counters.
// Ports    : none (package)
// Options  : INSTR_FETCH_PERF_CNT_EN (sat_inc32 is used only when defined)
// Revision : 1.0  initial release
// ============================================================================
package instr_fetch_pkg;

    localparam int DEF_ADDR_WIDTH     = 32;
    localparam int DEF_DATA_BIT_WIDTH = 32;
    localparam int DEF_PC_INC         = 4;
    localparam int DEF_BUF_DEPTH      = 2;

    // ST_ISSUE : free to issue a request (no request outstanding)
    // ST_WAIT  : one request outstanding, its response will be kept
    // ST_KILL  : one request outstanding, its response will be discarded
    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_KILL  = 2'd2
    } fetch_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (&value) ? value : value + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fifo.sv
`default_nettype none
// ============================================================================
// Module   : instr_fifo
// Purpose  : Small show-ahead FIFO holding fetched {pc, instruction} entries.
//            Flush has priority over push and pop. The head output reads 0
//            whenever the FIFO is empty.
// Ports    : clk        clock, rising edge
//            reset      asynchronous, active-low
//            push/din   write an entry
//            pop        remove the head entry
//            flush      discard all entries
//            head       current head entry (0 when empty)
//            count      occupancy
//            not_empty  head is valid
// Revision : 1.0  initial release
// ============================================================================
module instr_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic                           pop,
    input  logic                           flush,
    input  logic [WIDTH-1:0]               din,
    output logic [WIDTH-1:0]               head,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           not_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] occ;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (occ != '0);
    // A full FIFO only accepts a push when the head leaves in the same cycle.
    assign do_push = push && ((occ != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + CNT_W'(1);
                2'b01:   occ <= occ - CNT_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    assign not_empty = (occ != '0);
    assign count     = occ;
    assign head      = not_empty ? mem[rd_ptr] : '0;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Purpose  : Fetch stage ahead of the instruction decoder. Holds the PC,
//            issues one-at-a-time reads to instruction memory, buffers the
//            returned words and presents {instruction, pc} to the decoder
//            with a valid/ready handshake. A redirect flushes buffered and
//            in-flight fetches and restarts at the redirect target.
// Ports    : clk            clock, rising edge
//            reset          asynchronous, active-low
//            imem_req       one-cycle read request (memory always accepts)
//            imem_addr      request address
//            imem_rvalid    response strobe (one per request, latency >= 1)
//            imem_rdata     response word
//            redirect_valid flush and restart at redirect_pc
//            redirect_pc    new fetch address
//            instr_valid    head entry valid
//            instr_data     head instruction word (0 when empty)
//            instr_pc       head instruction address (0 when empty)
//            instr_ready    decoder accepts the head this cycle
//            perf_fetched   (option) saturating count of buffered words
//            perf_killed    (option) saturating count of discarded responses
//            perf_stall     (option) saturating count of valid&!ready cycles
// Options  : INSTR_FETCH_PERF_CNT_EN adds the perf_* outputs and counters.
// Revision : 1.0  initial release
// ============================================================================
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int                    DATA_BIT_WIDTH = DEF_DATA_BIT_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0,
    parameter int                    PC_INC         = DEF_PC_INC,
    parameter int                    BUF_DEPTH      = DEF_BUF_DEPTH
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic                      imem_req,
    output logic [ADDR_WIDTH-1:0]     imem_addr,
    input  logic                      imem_rvalid,
    input  logic [DATA_BIT_WIDTH-1:0] imem_rdata,
    input  logic                      redirect_valid,
    input  logic [ADDR_WIDTH-1:0]     redirect_pc,
    output logic                      instr_valid,
    output logic [DATA_BIT_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0]     instr_pc,
    input  logic                      instr_ready
`ifdef INSTR_FETCH_PERF_CNT_EN
    ,
    output logic [31:0]               perf_fetched,
    output logic [31:0]               perf_killed,
    output logic [31:0]               perf_stall
`endif
);

    localparam int ENT_W = ADDR_WIDTH + DATA_BIT_WIDTH;
    localparam int CNT_W = $clog2(BUF_DEPTH+1);
    localparam int OCC_W = CNT_W + 1;

    fetch_state_t          state;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] req_pc;

    logic                  push;
    logic                  pop;
    logic                  flush;
    logic                  issue;
    logic [CNT_W-1:0]      occ;
    logic [OCC_W-1:0]      occ_next;
    logic                  fifo_valid;
    logic [ENT_W-1:0]      head;

    // ------------------------------------------------------------------
    // Buffer
    // ------------------------------------------------------------------
    instr_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (flush),
        .din       ({req_pc, imem_rdata}),
        .head      (head),
        .count     (occ),
        .not_empty (fifo_valid)
    );

    assign pop = fifo_valid && instr_ready;

    // ------------------------------------------------------------------
    // Per-cycle decisions. A request is issued only when the word it will
    // bring back is guaranteed a slot, judged on the occupancy after this
    // cycle's push and pop; that is what lets a 1-cycle memory stream one
    // instruction per cycle without ever overflowing the buffer.
    // ------------------------------------------------------------------
    always_comb begin
        push  = 1'b0;
        flush = 1'b0;
        issue = 1'b0;
        case (state)
            ST_ISSUE: begin
                flush = redirect_valid;
            end
            ST_WAIT: begin
                flush = redirect_valid;
                push  = imem_rvalid && !redirect_valid;
            end
            ST_KILL: begin
                flush = redirect_valid;
            end
            default: begin
                flush = 1'b0;
            end
        endcase
        occ_next = OCC_W'(occ) + OCC_W'(push) - OCC_W'(pop);
        if (!redirect_valid &&
            ((state == ST_ISSUE) || ((state == ST_WAIT) && imem_rvalid)) &&
            (occ_next < OCC_W'(BUF_DEPTH))) begin
            issue = 1'b1;
        end
    end

    // Requests are held off while reset is asserted even though the state
    // registers already sit in ST_ISSUE.
    assign imem_req  = issue && reset;
    assign imem_addr = fetch_pc;

    // ------------------------------------------------------------------
    // Fetch FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_ISSUE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
        end else begin
            case (state)
                ST_ISSUE: begin
                    // A stray response here has no owner and is ignored.
                    if (redirect_valid) begin
                        fetch_pc <= redirect_pc;
                    end else if (issue) begin
                        req_pc   <= fetch_pc;
                        fetch_pc <= fetch_pc + ADDR_WIDTH'(PC_INC);
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (redirect_valid) begin
                            fetch_pc <= redirect_pc;
                            state    <= ST_ISSUE;
                        end else if (issue) begin
                            req_pc   <= fetch_pc;
                            fetch_pc <= fetch_pc + ADDR_WIDTH'(PC_INC);
                        end else begin
                            state    <= ST_ISSUE;
                        end
                    end else if (redirect_valid) begin
                        // The in-flight word belongs to the old path.
                        fetch_pc <= redirect_pc;
                        state    <= ST_KILL;
                    end
                end
                ST_KILL: begin
                    if (redirect_valid) begin
                        fetch_pc <= redirect_pc;
                    end
                    if (imem_rvalid) begin
                        state <= ST_ISSUE;
                    end
                end
                default: begin
                    state <= ST_ISSUE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Decoder-facing outputs
    // ------------------------------------------------------------------
    assign instr_valid = fifo_valid;
    assign instr_pc    = head[ENT_W-1 -: ADDR_WIDTH];
    assign instr_data  = head[DATA_BIT_WIDTH-1:0];

`ifdef INSTR_FETCH_PERF_CNT_EN
    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    logic killed_evt;
    logic stall_evt;

    assign killed_evt = imem_rvalid &&
                        ((state == ST_KILL) || ((state == ST_WAIT) && redirect_valid));
    assign stall_evt  = fifo_valid && !instr_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched <= '0;
            perf_killed  <= '0;
            perf_stall   <= '0;
        end else begin
            if (push) begin
                perf_fetched <= sat_inc32(perf_fetched);
            end
            if (killed_evt) begin
                perf_killed <= sat_inc32(perf_killed);
            end
            if (stall_evt) begin
                perf_stall <= sat_inc32(perf_stall);
            end
        end
    end
`endif

endmodule
`default_nettype wire
